// File: rtl/seq_normalizer_pkg.sv
// seq_normalizer_pkg: shared constants, FSM encoding and per-stage shift decision for the normalizer
package seq_normalizer_pkg;
    localparam int WIDTH = 32;
    localparam int AMT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
    function automatic logic stage_take(input logic [WIDTH-1:0] w, input logic [AMT_W-1:0] k, input logic sgn);
        logic [WIDTH-1:0] m;
        m = ~({WIDTH{1'b1}} >> ((32'd1 << k) + 32'(sgn)));
        return sgn ? ((w & m) == '0 || (w & m) == m) : ((w & m) == '0);
    endfunction
endpackage

// File: rtl/seq_normalizer_stage.sv
// norm_stage: one binary-search step (w, k, sgn in; shifted w and take bit out)
module norm_stage
    import seq_normalizer_pkg::*;
(
    input  logic [WIDTH-1:0] w,
    input  logic [AMT_W-1:0] k,
    input  logic             sgn,
    output logic [WIDTH-1:0] w_out,
    output logic             take
);
    always_comb begin
        take  = stage_take(w, k, sgn);
        w_out = take ? w << (32'd1 << k) : w;
    end
endmodule

// File: rtl/seq_normalizer.sv
// seq_normalizer: multi-cycle leading-zero/sign normalizer (CLK, RST, START, SIGNED_MODE, D_IN in; BUSY, DONE, D_OUT, SH_AMT, ZERO out)
module seq_normalizer
    import seq_normalizer_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SIGNED_MODE,
    input  logic [WIDTH-1:0] D_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D_OUT,
    output logic [AMT_W-1:0] SH_AMT,
    output logic             ZERO
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] w_q, w_d, dout_q, dout_d, stage_w;
    logic [AMT_W-1:0] k_q, k_d, sh_q, sh_d;
    logic             sgn_q, sgn_d, zero_q, zero_d, take;
    norm_stage u_stage (.w(w_q), .k(k_q), .sgn(sgn_q), .w_out(stage_w), .take(take));
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        k_d     = k_q;
        sh_d    = sh_q;
        sgn_d   = sgn_q;
        zero_d  = zero_q;
        dout_d  = dout_q;
        if (START && state_q != RUN) begin
            state_d = RUN;
            w_d     = D_IN;
            sgn_d   = SIGNED_MODE;
            k_d     = AMT_W'(AMT_W - 1);
            sh_d    = '0;
            zero_d  = 1'b0;
        end else if (state_q == RUN) begin
            w_d  = stage_w;
            sh_d = sh_q | (AMT_W'(take) << k_q);
            k_d  = k_q - AMT_W'(1);
            if (k_q == '0) begin
                state_d = FIN;
                dout_d  = stage_w;
                zero_d  = stage_w == '0;
            end
        end else if (state_q == FIN) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            w_q     <= '0;
            k_q     <= '0;
            sh_q    <= '0;
            sgn_q   <= 1'b0;
            zero_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            sgn_q   <= sgn_d;
            zero_q  <= zero_d;
            dout_q  <= dout_d;
        end
    end
    assign BUSY   = state_q == RUN;
    assign DONE   = state_q == FIN;
    assign D_OUT  = dout_q;
    assign SH_AMT = sh_q;
    assign ZERO   = zero_q;
endmodule
